// File: rtl/sdram_pkg.sv
// Shared SDRAM request/response word layout and a packing helper used by the
// arbiter, its clients and test code.
package sdram_pkg;

  localparam int REQ_W = 41;
  localparam int RSP_W = 41;

  localparam int REQ_WRITE_BIT = 40;
  localparam int REQ_ADDR_MSB  = 39;
  localparam int REQ_ADDR_LSB  = 16;
  localparam int REQ_DATA_MSB  = 15;
  localparam int REQ_DATA_LSB  = 0;

  // Physical address split inside the 24-bit address field.
  localparam int BANK_MSB = 39;
  localparam int BANK_LSB = 38;
  localparam int ROW_MSB  = 37;
  localparam int ROW_LSB  = 25;
  localparam int COL_MSB  = 24;
  localparam int COL_LSB  = 16;

  localparam int RSP_DATA_MSB = 15;
  localparam int RSP_DATA_LSB = 0;

  typedef logic [REQ_W-1:0] req_word_t;
  typedef logic [RSP_W-1:0] rsp_word_t;

  function automatic req_word_t pack_req(input logic        write,
                                         input logic [23:0] addr,
                                         input logic [15:0] wdata);
    req_word_t w;
    w = '0;
    w[REQ_WRITE_BIT]               = write;
    w[REQ_ADDR_MSB:REQ_ADDR_LSB]   = addr;
    w[REQ_DATA_MSB:REQ_DATA_LSB]   = wdata;
    return w;
  endfunction

  function automatic logic [1:0] req_bank(input req_word_t w);
    return w[BANK_MSB:BANK_LSB];
  endfunction

  function automatic logic [12:0] req_row(input req_word_t w);
    return w[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [8:0] req_col(input req_word_t w);
    return w[COL_MSB:COL_LSB];
  endfunction

endpackage

// File: rtl/sdram_req_arbiter_tag_fifo.sv
// Show-ahead FIFO of requester indices, one entry per request in flight;
// the head entry names the owner of the next in-order response.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM request/response FIFO pair among
// NUM_REQ clients, steering in-order responses back by a recorded tag.
module sdram_req_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int REQ_W           = sdram_pkg::REQ_W,
  parameter int RSP_W           = sdram_pkg::RSP_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 cl_req_valid,
  output logic [NUM_REQ-1:0]                 cl_req_ready,
  input  logic [NUM_REQ*REQ_W-1:0]           cl_req_data,
  output logic [NUM_REQ-1:0]                 cl_rsp_valid,
  input  logic [NUM_REQ-1:0]                 cl_rsp_ready,
  output logic [RSP_W-1:0]                   cl_rsp_data,
  output logic [REQ_W-1:0]                   req_fifo_data,
  output logic                               req_fifo_write,
  input  logic                               req_fifo_full,
  input  logic [RSP_W-1:0]                   rsp_fifo_data,
  output logic                               rsp_fifo_read,
  input  logic                               rsp_fifo_empty,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               err_orphan
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [REQ_W-1:0] req_data_q, req_data_d;
  logic             req_write_q, req_write_d;
  logic             err_orphan_q, err_orphan_d;

  logic [IDX_W-1:0] tag_head;
  logic             tag_empty, tag_full;
  logic [CNT_W-1:0] tag_count;

  logic             grant_ok, grant_found, transfer;
  logic [IDX_W-1:0] grant_idx, cand;
  logic             tag_pop, orphan_drop;

  // Round-robin scan from the requester after the last one served.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && cl_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A pending write strobe blocks the grant, which also hides the
  // one-cycle lag of the request FIFO full flag.
  always_comb begin
    grant_ok     = !rst && !req_fifo_full && !req_write_q && !tag_full;
    transfer     = grant_ok && grant_found;
    cl_req_ready = '0;
    if (transfer) begin
      cl_req_ready[grant_idx] = 1'b1;
    end
    req_write_d  = transfer;
    req_data_d   = transfer ? cl_req_data[int'(grant_idx) * REQ_W +: REQ_W] : req_data_q;
    last_grant_d = transfer ? grant_idx : last_grant_q;
  end

  // A response with no tag left belongs to a request lost across reset.
  always_comb begin
    cl_rsp_valid = '0;
    tag_pop      = 1'b0;
    orphan_drop  = 1'b0;
    if (!rst && !rsp_fifo_empty) begin
      if (!tag_empty) begin
        cl_rsp_valid[tag_head] = 1'b1;
        tag_pop                = cl_rsp_ready[tag_head];
      end else begin
        orphan_drop = 1'b1;
      end
    end
    rsp_fifo_read = tag_pop || orphan_drop;
    err_orphan_d  = err_orphan_q || orphan_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      req_data_q   <= '0;
      req_write_q  <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      req_data_q   <= req_data_d;
      req_write_q  <= req_write_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (transfer),
    .pop   (tag_pop),
    .din   (grant_idx),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full),
    .count (tag_count)
  );

  assign cl_rsp_data    = rsp_fifo_data;
  assign req_fifo_data  = req_data_q;
  assign req_fifo_write = req_write_q;
  assign outstanding    = tag_count;
  assign err_orphan     = err_orphan_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(cl_req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(cl_rsp_valid));
  a_strobe_1cyc:  assert property (@(posedge clk) disable iff (rst) req_fifo_write |=> !req_fifo_write);
  a_max_out:      assert property (@(posedge clk) disable iff (rst) outstanding <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Bench for sdram_req_arbiter: an SDRAM echo model behind the FIFO pair and a
// scoreboard of expected request pushes and routed responses.
module tb_sdram_req_arbiter;
  import sdram_pkg::*;

  localparam int NR = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NR-1:0]       cl_req_valid = '0;
  logic [NR-1:0]       cl_req_ready;
  logic [NR*REQ_W-1:0] cl_req_data = '0;
  logic [NR-1:0]       cl_rsp_valid;
  logic [NR-1:0]       cl_rsp_ready = '0;
  logic [RSP_W-1:0]    cl_rsp_data;
  logic [REQ_W-1:0]    req_fifo_data;
  logic                req_fifo_write;
  logic                req_fifo_full = 1'b0;
  logic [RSP_W-1:0]    rsp_fifo_data = '0;
  logic                rsp_fifo_read;
  logic                rsp_fifo_empty = 1'b1;
  logic [2:0]          outstanding;
  logic                err_orphan;

  int checks   = 0;
  int failures = 0;

  logic [REQ_W-1:0]       exp_req_q[$];
  logic [NR+RSP_W-1:0]    exp_rsp_q[$];

  // SDRAM model state: pipe_q holds answers not yet visible, rspf_q is the
  // show-ahead response FIFO seen by the DUT.
  logic [RSP_W-1:0] pipe_q[$];
  logic [RSP_W-1:0] rspf_q[$];
  bit               hold_rsp    = 1'b0;
  int               release_cnt = 0;

  sdram_req_arbiter #(
    .NUM_REQ         (NR),
    .MAX_OUTSTANDING (4),
    .REQ_W           (REQ_W),
    .RSP_W           (RSP_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cl_req_valid   (cl_req_valid),
    .cl_req_ready   (cl_req_ready),
    .cl_req_data    (cl_req_data),
    .cl_rsp_valid   (cl_rsp_valid),
    .cl_rsp_ready   (cl_rsp_ready),
    .cl_rsp_data    (cl_rsp_data),
    .req_fifo_data  (req_fifo_data),
    .req_fifo_write (req_fifo_write),
    .req_fifo_full  (req_fifo_full),
    .rsp_fifo_data  (rsp_fifo_data),
    .rsp_fifo_read  (rsp_fifo_read),
    .rsp_fifo_empty (rsp_fifo_empty),
    .outstanding    (outstanding),
    .err_orphan     (err_orphan)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [RSP_W-1:0] rsp_word(input logic [REQ_W-1:0] w);
    return {25'h0, w[15:0]};
  endfunction

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- SDRAM echo model ----------------
  always begin : sdram_model
    logic             rd, wr;
    logic [REQ_W-1:0] wd;
    @(negedge clk);
    rd = rsp_fifo_read;
    wr = req_fifo_write;
    wd = req_fifo_data;
    @(posedge clk);
    #1;
    if (rd && rspf_q.size() > 0) void'(rspf_q.pop_front());
    if (wr) pipe_q.push_back(rsp_word(wd));
    while (pipe_q.size() > 0 && (!hold_rsp || release_cnt > 0)) begin
      rspf_q.push_back(pipe_q.pop_front());
      if (hold_rsp) release_cnt--;
    end
    rsp_fifo_empty = (rspf_q.size() == 0);
    rsp_fifo_data  = (rspf_q.size() == 0) ? '0 : rspf_q[0];
  end

  // ---------------- scoreboard ----------------
  logic prev_wr = 1'b0;
  always begin : scoreboard
    logic [REQ_W-1:0]    er;
    logic [NR+RSP_W-1:0] es;
    @(negedge clk);
    if (!rst) begin
      if (req_fifo_write) begin
        checks++;
        if (exp_req_q.size() == 0) begin
          failures++;
          $display("FAIL req_push: unexpected push data=%h", req_fifo_data);
        end else begin
          er = exp_req_q.pop_front();
          if (req_fifo_data !== er) begin
            failures++;
            $display("FAIL req_push: data=%h expected=%h", req_fifo_data, er);
          end
        end
        checks++;
        if (prev_wr) begin
          failures++;
          $display("FAIL req_strobe: write high two cycles in a row");
        end
      end
      if ((cl_rsp_valid & cl_rsp_ready) != '0) begin
        checks++;
        if (exp_rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_route: unexpected delivery valid=%b data=%h", cl_rsp_valid, cl_rsp_data);
        end else begin
          es = exp_rsp_q.pop_front();
          if ({cl_rsp_valid, cl_rsp_data} !== es) begin
            failures++;
            $display("FAIL rsp_route: valid=%b data=%h expected valid=%b data=%h",
                     cl_rsp_valid, cl_rsp_data, es[NR+RSP_W-1:RSP_W], es[RSP_W-1:0]);
          end
        end
      end
    end
    prev_wr = req_fifo_write;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_req(input int idx, input logic [REQ_W-1:0] w, output bit ok);
    ok = 1'b0;
    cl_req_data[idx*REQ_W +: REQ_W] = w;
    cl_req_valid[idx] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cl_req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    cl_req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (outstanding == 3'd0 && rsp_fifo_empty && pipe_q.size() == 0 && !req_fifo_write) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic expect_pair(input int idx, input logic [REQ_W-1:0] w);
    exp_req_q.push_back(w);
    exp_rsp_q.push_back({oh(idx), rsp_word(w)});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cl_req_valid = 2'b11;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({cl_req_ready, cl_rsp_valid, req_fifo_write, rsp_fifo_read, err_orphan} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b wr=%b rd=%b err=%b expected all 0",
               cl_req_ready, cl_rsp_valid, req_fifo_write, rsp_fifo_read, err_orphan);
    end
    checks++;
    if (req_fifo_data !== '0 || outstanding !== 3'd0) begin
      failures++;
      $display("FAIL reset_data: data=%h outstanding=%0d expected 0/0", req_fifo_data, outstanding);
    end
    tick();
    rst = 1'b0;
    cl_req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    logic [REQ_W-1:0] w;
    int n;
    bit ok;
    w = pack_req(1'b1, 24'h000010, 16'h1234);
    exp_req_q.push_back(41'h1_000010_1234);
    exp_rsp_q.push_back({2'b01, 25'h0, 16'h1234});
    cl_rsp_ready = '0;
    cl_req_data[0 +: REQ_W] = w;
    cl_req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (cl_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: ready=%b expected 01", cl_req_ready);
    end
    tick();
    cl_req_valid = '0;
    @(negedge clk);
    checks++;
    if (req_fifo_write !== 1'b1 || outstanding !== 3'd1) begin
      failures++;
      $display("FAIL single_push: wr=%b outstanding=%0d expected 1/1", req_fifo_write, outstanding);
    end
    n = 0;
    while (cl_rsp_valid == '0 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (cl_rsp_valid !== 2'b01 || cl_rsp_data !== {25'h0, 16'h1234} || rsp_fifo_read !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: valid=%b data=%h rd=%b expected 01/1234/0",
               cl_rsp_valid, cl_rsp_data, rsp_fifo_read);
    end
    tick();
    cl_rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (rsp_fifo_read !== 1'b1) begin
      failures++;
      $display("FAIL single_pop: rd=%b expected 1", rsp_fifo_read);
    end
    tick();
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0 || cl_rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_done: outstanding=%0d valid=%b expected 0/00", outstanding, cl_rsp_valid);
    end
    wait_idle(ok);
  endtask

  task automatic test_fairness();
    logic [REQ_W-1:0] w0, w1;
    logic [NR-1:0]    exp_rdy;
    bit ok;
    w0 = pack_req(1'b0, 24'h000100, 16'h00A0);
    w1 = pack_req(1'b1, 24'h000200, 16'h00B1);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) expect_pair(1, w1);
      else            expect_pair(0, w0);
    end
    cl_rsp_ready = 2'b11;
    cl_req_data  = {w1, w0};
    cl_req_valid = 2'b11;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_rdy = (i % 2 == 1) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
      checks++;
      if (cl_req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL fair_grant[%0d]: ready=%b expected %b", i, cl_req_ready, exp_rdy);
      end
      checks++;
      if (req_fifo_write !== ((i % 2) == 1)) begin
        failures++;
        $display("FAIL fair_strobe[%0d]: wr=%b expected %b", i, req_fifo_write, (i % 2) == 1);
      end
      tick();
    end
    cl_req_valid = '0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fair_drain: outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_outstanding_limit();
    logic [REQ_W-1:0] w0, w1;
    int n;
    bit ok;
    w0 = pack_req(1'b0, 24'h000300, 16'h0C00);
    w1 = pack_req(1'b0, 24'h000400, 16'h0C11);
    expect_pair(1, w1);
    expect_pair(0, w0);
    expect_pair(1, w1);
    expect_pair(0, w0);
    expect_pair(1, w1);
    hold_rsp     = 1'b1;
    release_cnt  = 0;
    cl_rsp_ready = 2'b11;
    cl_req_data  = {w1, w0};
    cl_req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if ((cl_req_valid & cl_req_ready) != '0) n++;
      tick();
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL limit_count: transfers=%0d expected 4", n);
    end
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd4 || cl_req_ready !== 2'b00) begin
      failures++;
      $display("FAIL limit_full: outstanding=%0d ready=%b expected 4/00", outstanding, cl_req_ready);
    end
    tick();
    release_cnt = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((cl_req_valid & cl_req_ready) != '0) n++;
      tick();
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL limit_release: transfers=%0d expected 1", n);
    end
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd4) begin
      failures++;
      $display("FAIL limit_refill: outstanding=%0d expected 4", outstanding);
    end
    tick();
    cl_req_valid = '0;
    hold_rsp     = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL limit_drain: outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_routing();
    logic [REQ_W-1:0] wa, wb, wc;
    bit ok;
    int n;
    wa = pack_req(1'b0, 24'h000500, 16'hAAAA);
    wb = pack_req(1'b0, 24'h000510, 16'hBBBB);
    wc = pack_req(1'b0, 24'h000520, 16'hCCCC);
    expect_pair(1, wa);
    expect_pair(0, wb);
    expect_pair(1, wc);
    hold_rsp     = 1'b1;
    cl_rsp_ready = 2'b10;
    send_req(1, wa, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL route_grant_a: no grant seen=0 expected=1"); end
    send_req(0, wb, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL route_grant_b: no grant seen=0 expected=1"); end
    send_req(1, wc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL route_grant_c: no grant seen=0 expected=1"); end
    tick();
    hold_rsp = 1'b0;
    n = 0;
    @(negedge clk);
    while (cl_rsp_valid !== 2'b01 && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (cl_rsp_valid !== 2'b01 || cl_rsp_data !== rsp_word(wb) || rsp_fifo_read !== 1'b0) begin
      failures++;
      $display("FAIL route_stall: valid=%b data=%h rd=%b expected 01/%h/0",
               cl_rsp_valid, cl_rsp_data, rsp_fifo_read, rsp_word(wb));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (cl_rsp_valid !== 2'b01 || cl_rsp_data !== rsp_word(wb) || rsp_fifo_read !== 1'b0 ||
          outstanding !== 3'd2) begin
        failures++;
        $display("FAIL route_hold[%0d]: valid=%b data=%h rd=%b out=%0d expected 01/%h/0/2",
                 i, cl_rsp_valid, cl_rsp_data, rsp_fifo_read, outstanding, rsp_word(wb));
      end
    end
    tick();
    cl_rsp_ready = 2'b11;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL route_drain: outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_backpressure();
    logic [REQ_W-1:0] w;
    bit ok;
    w = pack_req(1'b1, 24'h000600, 16'h0D0D);
    expect_pair(0, w);
    req_fifo_full = 1'b1;
    cl_req_data[0 +: REQ_W] = w;
    cl_req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (cl_req_ready !== 2'b00 || req_fifo_write !== 1'b0) begin
        failures++;
        $display("FAIL bp_block[%0d]: ready=%b wr=%b expected 00/0", i, cl_req_ready, req_fifo_write);
      end
      tick();
    end
    req_fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (cl_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL bp_release: ready=%b expected 01", cl_req_ready);
    end
    tick();
    cl_req_valid = '0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_drain: outstanding=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_orphan_reset();
    logic [REQ_W-1:0] w0, w1;
    bit ok;
    int nrd, nval;
    w0 = pack_req(1'b0, 24'h000700, 16'h0E00);
    w1 = pack_req(1'b1, 24'h000710, 16'h0E11);
    exp_req_q.push_back(w1);
    exp_req_q.push_back(w0);
    hold_rsp     = 1'b1;
    cl_rsp_ready = 2'b11;
    send_req(1, w1, ok);
    send_req(0, w0, ok);
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd2) begin
      failures++;
      $display("FAIL orphan_pre: outstanding=%0d expected 2", outstanding);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0 || err_orphan !== 1'b0 || cl_rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL orphan_rst: out=%0d err=%b valid=%b expected 0/0/00",
               outstanding, err_orphan, cl_rsp_valid);
    end
    tick();
    hold_rsp = 1'b0;
    nrd  = 0;
    nval = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_fifo_read) nrd++;
      if (cl_rsp_valid != '0) nval++;
      tick();
    end
    checks++;
    if (nrd != 2 || nval != 0) begin
      failures++;
      $display("FAIL orphan_drop: reads=%0d valid_cycles=%0d expected 2/0", nrd, nval);
    end
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1 || rsp_fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL orphan_flag: err=%b empty=%b expected 1/1", err_orphan, rsp_fifo_empty);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin
      failures++;
      $display("FAIL orphan_sticky: err=%b expected 1", err_orphan);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b0) begin
      failures++;
      $display("FAIL orphan_clear: err=%b expected 0", err_orphan);
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_outstanding_limit();
    test_routing();
    test_backpressure();
    test_orphan_reset();
    checks++;
    if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: req=%0d rsp=%0d expected 0/0", exp_req_q.size(), exp_rsp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the single SDRAM request/response FIFO pair (fifo_to_dram / fifo_from_dram) among NUM_REQ client masters, e.g. the memory tester and a future video scanout engine.
- Grants requests round-robin and pushes them into the request FIFO.
- Records the requester index of every outstanding request, in order.
- Steers each in-order response from the response FIFO back to the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- MAX_OUTSTANDING, 4, maximum requests in flight; tag FIFO depth (power of 2)
- REQ_W, 41, request word: {write, addr[23:0], wdata[15:0]}
- RSP_W, 41, response word; rdata in [15:0]

Ports:
- clk  in  1  system clock (48 MHz domain)
- rst  in  1  synchronous active-high reset
- cl_req_valid  in  NUM_REQ  per-requester request valid
- cl_req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid&ready
- cl_req_data  in  NUM_REQ*REQ_W  flattened request words; requester i at [i*REQ_W +: REQ_W]
- cl_rsp_valid  out  NUM_REQ  response valid, one-hot or zero
- cl_rsp_ready  in  NUM_REQ  per-requester response accept
- cl_rsp_data  out  RSP_W  response word, broadcast to all requesters
- req_fifo_data  out  REQ_W  to request FIFO data_in
- req_fifo_write  out  1  to request FIFO write_enable
- req_fifo_full  in  1  request FIFO full
- rsp_fifo_data  in  RSP_W  response FIFO data_out; show-ahead, valid while empty=0
- rsp_fifo_read  out  1  response FIFO read_enable (pop)
- rsp_fifo_empty  in  1  response FIFO empty
- outstanding  out  clog2(MAX_OUTSTANDING+1)  requests in flight
- err_orphan  out  1  sticky flag: a response arrived with no outstanding tag

Behaviour:
- Reset values: cl_req_ready=0, cl_rsp_valid=0, req_fifo_write=0, req_fifo_data=0, rsp_fifo_read=0, outstanding=0, err_orphan=0. The round-robin pointer is set so that requester 0 has top priority.
- Grant eligibility (combinational):
  - req_fifo_full=0, and
  - req_fifo_write=0 (at most one push every 2 cycles, which covers the one-cycle lag of the full flag), and
  - outstanding<MAX_OUTSTANDING.
- Round-robin grant:
  - Scan starts at last_grant+1 and wraps at NUM_REQ-1 -> 0.
  - The first requester with valid=1 gets cl_req_ready=1; at most one ready bit is set per cycle.
  - last_grant updates only on an actual transfer.
- Push:
  - On a transfer, req_fifo_data is registered from the granted word.
  - req_fifo_write=1 on the next cycle, for exactly 1 cycle.
  - The requester index is pushed into the tag FIFO in the transfer cycle.
  - Request latency: valid&ready -> write strobe = 1 cycle.
- Response steering (combinational):
  - When rsp_fifo_empty=0 and the tag FIFO is non-empty, head tag t drives cl_rsp_valid[t]=1 and cl_rsp_data=rsp_fifo_data.
  - rsp_fifo_read = cl_rsp_valid[t] & cl_rsp_ready[t]; the same condition pops the tag.
  - Hold rule: cl_rsp_valid stays high with stable data until accepted. No timeout.
- Orphan response:
  - Condition: rsp_fifo_empty=0 and the tag FIFO is empty.
  - Assert rsp_fifo_read for 1 cycle to drop the word. No cl_rsp_valid.
  - Set err_orphan=1; it clears only on rst.
- outstanding: +1 on a transfer, -1 on a tag pop. A simultaneous transfer and pop leaves it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- Requesters may drop valid without a grant. The arbiter does not latch a pending request.
- Both writes and reads produce exactly one response (write -> ack word). Every transfer is therefore tagged.
- Reset mid-operation:
  - The tag FIFO and counter are cleared; any pending req_fifo_write is cancelled.
  - Responses already in the SDRAM pipeline then arrive as orphans. They are dropped and set err_orphan. The system resets the SDRAM path together with this block.

Decomposition:
- sdram_pkg:
  - REQ_W, RSP_W
  - field positions: REQ_WRITE_BIT=40, REQ_ADDR_MSB/LSB=39/16, REQ_DATA_MSB/LSB=15/0
  - BANK bits [39:38], ROW [37:25], COL [24:16]
  - the request-word packing function
- Sub-module tag_fifo:
  - synchronous, depth MAX_OUTSTANDING, width clog2(NUM_REQ), show-ahead
  - ports: push, pop, din, dout, empty, full, count
  - count drives outstanding.

Test Plan:
- Single requester: req0 write addr 0x000010 data 0x1234 -> req_fifo_data=0x1_000010_1234 with a 1-cycle write strobe; response word pushed -> cl_rsp_valid=01, rsp_fifo_read pulses on cl_rsp_ready[0], outstanding 1->0.
- Fairness: both requesters hold valid continuously, responses returned promptly -> grant order 0,1,0,1… with exactly 1 write strobe every 2 cycles.
- Outstanding limit: 4 responses withheld, 6 requests offered -> exactly 4 transfers, outstanding=4, ready=0; releasing 1 response -> 1 more transfer.
- Routing order: grants req1,req0,req1, responses 0xAAAA,0xBBBB,0xCCCC -> delivered to 1,0,1 in order; requester 0 holding rsp_ready=0 stalls the 2nd response with no pop.
- Backpressure: req_fifo_full=1 for 10 cycles -> no ready, no write; first grant on the cycle full deasserts.
- Orphan/reset: rst with 2 outstanding, then 2 responses arrive -> both popped, no cl_rsp_valid, err_orphan=1 until the next rst.
